apb_master_mc: RTL and testbench

//  Parametrised APB4 requester: accepts one command per valid/ready handshake and

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_master_mc.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_mc.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, response error codes and
// the slave-index to one-hot select helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apbState_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_DECERR  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  // Widest select the helper can produce; callers truncate to NUM_SLV bits.
  localparam int MAX_SLV = 32;

  function automatic logic [MAX_SLV-1:0] idxToOnehot(input logic [4:0] idx);
    logic [MAX_SLV-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase: clears on request, counts enabled
// cycles, saturates at TIMEOUT_CYC and flags the cycle in which it gets there.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expires in the low-pready cycle whose increment makes the count reach the limit.
  assign expired_o = (TIMEOUT_CYC != 0) && enable_i && (count_d == CNT_MAX);

endmodule

// File: rtl/apb_master_mc.sv
// APB4 requester: one command per valid/ready handshake, one-hot psel from the top
// address bits, slave/decode/timeout errors reported on a single-cycle response.
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [DATA_W/8-1:0]       cmd_strb,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SIDX_W = $clog2(NUM_SLV);
  localparam int STRB_W = DATA_W / 8;

  apbState_e          state_q, state_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [STRB_W-1:0]  pstrb_q, pstrb_d;
  logic               rspValid_q, rspErr_q, rspTimeout_q;
  logic [DATA_W-1:0]  rspRdata_q, rspRdata_d;
  logic               pendDecErr_q, pendDecErr_d;
  logic [1:0]         rspCode;
  logic               rspFire, doLoad, doClear, accept;
  logic [SIDX_W-1:0]  cmdIdx;
  logic               cmdDecErr, selReady, selErr, timerExpired;
  logic [DATA_W-1:0]  selRdata;

  assign cmdIdx    = cmd_addr[ADDR_W-1 -: SIDX_W];
  assign cmdDecErr = 32'(cmdIdx) >= 32'(NUM_SLV);
  assign selReady  = |(pready & psel_q);
  assign selErr    = |(pslverr & psel_q);
  assign cmd_ready = presetn && ((state_q == IDLE) || ((state_q == ACCESS) && selReady));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    selRdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) selRdata = selRdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .pclk     (pclk),
    .presetn  (presetn),
    .clear_i  (state_q == SETUP),
    .enable_i ((state_q == ACCESS) && !selReady),
    .expired_o(timerExpired)
  );

  // A decode error accepted on a completing cycle would collide with that
  // completion's response, so it is parked in pendDecErr and reported from IDLE.
  always_comb begin
    state_d      = state_q;
    pendDecErr_d = pendDecErr_q;
    rspFire      = 1'b0;
    rspCode      = RSP_OK;
    rspRdata_d   = '0;
    doLoad       = 1'b0;
    doClear      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pendDecErr_q) begin
          rspFire = 1'b1;
          rspCode = RSP_DECERR;
        end
        pendDecErr_d = 1'b0;
        if (accept) begin
          if (!cmdDecErr) begin
            doLoad  = 1'b1;
            state_d = SETUP;
          end else if (pendDecErr_q) begin
            pendDecErr_d = 1'b1;
          end else begin
            rspFire = 1'b1;
            rspCode = RSP_DECERR;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (selReady) begin
          rspFire    = 1'b1;
          rspCode    = selErr ? RSP_SLVERR : RSP_OK;
          rspRdata_d = (!pwrite_q && !selErr) ? selRdata : '0;
          doClear    = 1'b1;
          state_d    = IDLE;
          if (accept) begin
            if (cmdDecErr) begin
              pendDecErr_d = 1'b1;
            end else begin
              doLoad  = 1'b1;
              state_d = SETUP;
            end
          end
        end else if (timerExpired) begin
          rspFire = 1'b1;
          rspCode = RSP_TIMEOUT;
          doClear = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = psel_q;
    penable_d = (state_q == SETUP) ? 1'b1 : penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    if (doClear) begin
      psel_d    = '0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
    end
    if (doLoad) begin
      psel_d    = NUM_SLV'(idxToOnehot(5'(cmdIdx)));
      penable_d = 1'b0;
      pwrite_d  = cmd_write;
      paddr_d   = cmd_addr;
      pwdata_d  = cmd_write ? cmd_wdata : '0;
      pstrb_d   = cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rspValid_q   <= 1'b0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      rspRdata_q   <= '0;
      pendDecErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rspValid_q   <= rspFire;
      rspErr_q     <= rspFire && (rspCode != RSP_OK);
      rspTimeout_q <= rspFire && (rspCode == RSP_TIMEOUT);
      rspRdata_q   <= rspRdata_d;
      pendDecErr_q <= pendDecErr_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_err     = rspErr_q;
  assign rsp_timeout = rspTimeout_q;
  assign rsp_rdata   = rspRdata_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Scenario bench for apb_master_mc: a 4-slave instance for the transfer tests and
// a 3-slave instance for the decode-error case, with expected responses queued.
module tb_apb_master_mc;

  typedef struct packed {
    logic       err;
    logic       tmo;
    logic [7:0] rdata;
  } rsp_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmdValid = 1'b0, cmdValid3 = 1'b0, cmdWrite = 1'b0;
  logic [7:0]  cmdAddr = '0, cmdWdata = '0;
  logic [0:0]  cmdStrb = '0;
  logic        cmdReady, rspValid, rspErr, rspTimeout, penable, pwrite;
  logic [7:0]  rspRdata, paddr, pwdata;
  logic [0:0]  pstrb;
  logic [3:0]  psel;
  logic [3:0]  pready = '0, pslverr = '0;
  logic [31:0] prdata = '0;
  logic        cmdReady3, rspValid3, rspErr3, rspTimeout3, penable3, pwrite3;
  logic [7:0]  rspRdata3, paddr3, pwdata3;
  logic [0:0]  pstrb3;
  logic [2:0]  psel3;
  logic [2:0]  pready3 = 3'b111, pslverr3 = '0;
  logic [23:0] prdata3 = '0;

  int   checks = 0;
  int   errors = 0;
  rsp_t expQ[$];
  rsp_t expQ3[$];

  always #5 pclk = ~pclk;

  apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(4), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_write(cmdWrite), .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata), .cmd_strb(cmdStrb),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr), .rsp_timeout(rspTimeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT_CYC(16)) dut3 (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmdValid3), .cmd_ready(cmdReady3),
    .cmd_write(cmdWrite), .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata), .cmd_strb(cmdStrb),
    .rsp_valid(rspValid3), .rsp_rdata(rspRdata3), .rsp_err(rspErr3), .rsp_timeout(rspTimeout3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .pstrb(pstrb3), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3)
  );

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({cmdReady, rspValid, rspErr, rspTimeout, rspRdata, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h required 0",
               {cmdReady, rspValid, rspErr, rspTimeout, rspRdata, psel, penable, pwrite, paddr, pwdata, pstrb});
    end
    checks++;
    if ({cmdReady3, rspValid3, rspErr3, rspTimeout3, rspRdata3, psel3, penable3, pwrite3, paddr3, pwdata3, pstrb3} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs3 got %h required 0",
               {cmdReady3, rspValid3, rspErr3, rspTimeout3, rspRdata3, psel3, penable3, pwrite3, paddr3, pwdata3, pstrb3});
    end
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (cmdReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready got %b required 1", cmdReady);
    end
  endtask

  task automatic test_write();
    rsp_t exp;
    pready = 4'b1111; pslverr = '0;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 8'h45; cmdWdata = 8'hA5; cmdStrb = 1'b1;
    expQ.push_back(rsp_t'{1'b0, 1'b0, 8'h00});
    @(negedge pclk);
    cmdValid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, rspValid} !== {4'b0010, 1'b0, 1'b1, 8'h45, 8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_setup got %h required %h", {psel, penable, pwrite, paddr, pwdata, pstrb, rspValid},
               {4'b0010, 1'b0, 1'b1, 8'h45, 8'hA5, 1'b1, 1'b0});
    end
    @(negedge pclk);
    checks++;
    if ({psel, penable, cmdReady, rspValid} !== {4'b0010, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_access got %b required 0010110", {psel, penable, cmdReady, rspValid});
    end
    @(negedge pclk);
    checks++;
    if ({psel, penable, paddr, rspValid} !== {4'b0000, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL write_rsp_cycle got %h required %h", {psel, penable, paddr, rspValid}, {4'b0, 1'b0, 8'h0, 1'b1});
    end
    if (rspValid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      checks++;
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL write_rsp got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    @(negedge pclk);
    checks++;
    if (rspValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsp_pulse got %b required 0", rspValid);
    end
  endtask

  task automatic test_read_wait();
    rsp_t exp;
    int   penCnt = 0;
    int   n = 0;
    pready = '0; prdata = {8'h5A, 8'h33, 8'h22, 8'h11};
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 8'hC3; cmdWdata = 8'hFF; cmdStrb = 1'b1;
    expQ.push_back(rsp_t'{1'b0, 1'b0, 8'h5A});
    @(negedge pclk);
    cmdValid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {4'b1000, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL read_setup got %h required %h", {psel, penable, pwrite, paddr, pwdata, pstrb},
               {4'b1000, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b0});
    end
    while (rspValid !== 1'b1 && n < 40) begin
      @(negedge pclk);
      n++;
      if (penable === 1'b1) begin
        penCnt++;
        if (penCnt == 4) pready = 4'b1000;
      end
    end
    pready = '0;
    checks++;
    if (penCnt != 4) begin
      errors++;
      $display("[TB] FAIL read_penable_cycles got %0d required 4", penCnt);
    end
    checks++;
    if (rspValid !== 1'b1 || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL read_rsp_timeout got rsp_valid=%b required 1", rspValid);
    end else begin
      exp = expQ.pop_front();
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL read_rsp got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t exp;
    pready = 4'b0001; prdata = {8'h5A, 8'h33, 8'h22, 8'h11};
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 8'h05;
    expQ.push_back(rsp_t'{1'b0, 1'b0, 8'h11});
    @(negedge pclk);
    checks++;
    if ({psel, penable, paddr, cmdReady} !== {4'b0001, 1'b0, 8'h05, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_setup1 got %h required %h", {psel, penable, paddr, cmdReady}, {4'b0001, 1'b0, 8'h05, 1'b0});
    end
    cmdAddr = 8'h0A;
    expQ.push_back(rsp_t'{1'b0, 1'b0, 8'h77});
    @(negedge pclk);
    checks++;
    if ({psel, penable, cmdReady} !== {4'b0001, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_access1 got %b required 000111", {psel, penable, cmdReady});
    end
    @(negedge pclk);
    cmdValid = 1'b0;
    checks++;
    if ({psel, penable, paddr, rspValid} !== {4'b0001, 1'b0, 8'h0A, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_setup2 got %h required %h", {psel, penable, paddr, rspValid}, {4'b0001, 1'b0, 8'h0A, 1'b1});
    end
    if (rspValid === 1'b1 && expQ.size() > 0) begin
      exp = expQ.pop_front();
      checks++;
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_rsp1 got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    prdata[7:0] = 8'h77;
    @(negedge pclk);
    checks++;
    if ({psel, penable} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_access2 got %b required 00011", {psel, penable});
    end
    @(negedge pclk);
    checks++;
    if ({psel, rspValid} !== {4'b0000, 1'b1} || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL b2b_end got %b required 00001", {psel, rspValid});
    end else begin
      exp = expQ.pop_front();
      checks++;
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_rsp2 got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    pready = '0;
  endtask

  task automatic test_slverr();
    rsp_t exp;
    int   n = 0;
    pready = 4'b0100; pslverr = 4'b0100; prdata = {8'h5A, 8'h33, 8'h22, 8'h11};
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 8'h80;
    expQ.push_back(rsp_t'{1'b1, 1'b0, 8'h00});
    @(negedge pclk);
    cmdValid = 1'b0;
    while (rspValid !== 1'b1 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (rspValid !== 1'b1 || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL slverr_rsp_timeout got rsp_valid=%b required 1", rspValid);
    end else begin
      exp = expQ.pop_front();
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL slverr_rsp got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    pready = '0; pslverr = '0;
  endtask

  task automatic test_timeout();
    rsp_t exp;
    int   penCnt = 0;
    int   n = 0;
    pready = '0;
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 8'h40;
    expQ.push_back(rsp_t'{1'b1, 1'b1, 8'h00});
    @(negedge pclk);
    cmdValid = 1'b0;
    while (rspValid !== 1'b1 && n < 60) begin
      @(negedge pclk);
      n++;
      if (penable === 1'b1) penCnt++;
    end
    checks++;
    if (penCnt != 16) begin
      errors++;
      $display("[TB] FAIL timeout_cycles got %0d required 16", penCnt);
    end
    checks++;
    if (rspValid !== 1'b1 || {psel, penable} !== 5'b0 || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL timeout_abort got rsp_valid=%b psel=%b penable=%b required 1 0000 0", rspValid, psel, penable);
    end else begin
      exp = expQ.pop_front();
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL timeout_rsp got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    n = 0;
    pready = 4'b0010;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 8'h41; cmdWdata = 8'h3C; cmdStrb = 1'b1;
    expQ.push_back(rsp_t'{1'b0, 1'b0, 8'h00});
    @(negedge pclk);
    cmdValid = 1'b0;
    while (rspValid !== 1'b1 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (rspValid !== 1'b1 || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL after_timeout_rsp got rsp_valid=%b required 1", rspValid);
    end else begin
      exp = expQ.pop_front();
      if ({rspErr, rspTimeout, rspRdata} !== exp) begin
        errors++;
        $display("[TB] FAIL after_timeout_data got %h required %h", {rspErr, rspTimeout, rspRdata}, exp);
      end
    end
    pready = '0;
  endtask

  task automatic test_decode_err();
    rsp_t exp;
    cmdValid3 = 1'b1; cmdWrite = 1'b0; cmdAddr = 8'hC0;
    expQ3.push_back(rsp_t'{1'b1, 1'b0, 8'h00});
    @(negedge pclk);
    cmdValid3 = 1'b0;
    checks++;
    if ({rspValid3, psel3, penable3, paddr3, cmdReady3} !== {1'b1, 3'b000, 1'b0, 8'h00, 1'b1} || expQ3.size() == 0) begin
      errors++;
      $display("[TB] FAIL decode_cycle got %h required %h", {rspValid3, psel3, penable3, paddr3, cmdReady3},
               {1'b1, 3'b000, 1'b0, 8'h00, 1'b1});
    end else begin
      exp = expQ3.pop_front();
      checks++;
      if ({rspErr3, rspTimeout3, rspRdata3} !== exp) begin
        errors++;
        $display("[TB] FAIL decode_rsp got %h required %h", {rspErr3, rspTimeout3, rspRdata3}, exp);
      end
    end
    @(negedge pclk);
    checks++;
    if ({rspValid3, psel3, pwrite3, pwdata3, pstrb3} !== '0) begin
      errors++;
      $display("[TB] FAIL decode_after got %h required 0", {rspValid3, psel3, pwrite3, pwdata3, pstrb3});
    end
  endtask

  task automatic test_reset_access();
    int sawRsp = 0;
    pready = '0;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 8'h45; cmdWdata = 8'h99; cmdStrb = 1'b1;
    @(negedge pclk);
    cmdValid = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel, penable} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rst_pre_access got %b required 00101", {psel, penable});
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({cmdReady, rspValid, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async got %h required 0", {cmdReady, rspValid, psel, penable, pwrite, paddr, pwdata, pstrb});
    end
    @(negedge pclk);
    presetn = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      if (rspValid !== 1'b0) sawRsp++;
    end
    checks++;
    if (sawRsp != 0) begin
      errors++;
      $display("[TB] FAIL rst_no_rsp got %0d responses required 0", sawRsp);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_decode_err();
    test_reset_access();
    checks++;
    if (expQ.size() != 0 || expQ3.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d/%0d left required 0/0", expQ.size(), expQ3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
